// File: rtl/soc_pio_pkg.sv
// Shared register offsets and edge-mode encodings for the switch/button input PIO.
package soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RAW     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_switches_irq_if.sv
// Avalon-MM slave bus plus level interrupt between the HPS lightweight bridge and the PIO.
interface soc_system_switches_irq_if;

    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, write_n, writedata, input readdata, irq);
    modport slave  (input address, write_n, writedata, output readdata, irq);

endinterface

// File: rtl/switch_debounce_bit.sv
// One input bit: synchroniser chain feeding a stable-count debouncer.
module switch_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic sync,
    output logic stable
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[SYNC_STAGES-2:0], pin};
    end

    assign sync = chain[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES <= 1) begin : g_bypass
            always_ff @(posedge clk) begin
                if (!reset_n) stable <= 1'b0;
                else          stable <= sync;
            end
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] count;

            // Any sample agreeing with stable restarts the run, so the count never passes LAST.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    count  <= '0;
                    stable <= 1'b0;
                end else if (sync == stable) begin
                    count <= '0;
                end else if (count >= LAST) begin
                    stable <= sync;
                    count  <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/soc_system_switches_irq.sv
// Input PIO for board switches: per-bit debounce, edge capture with W1C, mask and level IRQ.
module soc_system_switches_irq
    import soc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = EDGE_RISING
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in_port,
    soc_system_switches_irq_if.slave   bus
);

    localparam int PRIME_MAX = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int PW        = $clog2(PRIME_MAX + 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c;
    logic [PW-1:0]    prime_count;
    logic             primed;
    logic [31:0]      read_word;
    logic [31:0]      read_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            switch_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk     (clk),
                .reset_n (reset_n),
                .pin     (in_port[i]),
                .sync    (sync[i]),
                .stable  (stable[i])
            );
        end
    endgenerate

    // Edges are ignored until pins held at power-up have had time to settle into stable.
    assign primed = (prime_count == PW'(PRIME_MAX));

    always_comb begin
        case (EDGE_MODE)
            EDGE_FALLING: edge_hit = ~stable & stable_d;
            EDGE_ANY:     edge_hit = stable ^ stable_d;
            default:      edge_hit = stable & ~stable_d;
        endcase
        if (!primed) edge_hit = '0;
    end

    assign w1c = (!bus.write_n && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        read_word = '0;
        case (bus.address)
            ADDR_DATA:    read_word[WIDTH-1:0] = stable;
            ADDR_RAW:     read_word[WIDTH-1:0] = sync;
            ADDR_IRQMASK: read_word[WIDTH-1:0] = irq_mask;
            default:      read_word[WIDTH-1:0] = edge_capture;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_d     <= '0;
            prime_count  <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            read_q       <= '0;
        end else begin
            stable_d <= stable;
            if (!primed) prime_count <= prime_count + PW'(1);
            if (!bus.write_n && bus.address == ADDR_IRQMASK)
                irq_mask <= bus.writedata[WIDTH-1:0];
            // A new edge in the same cycle as its clear survives.
            edge_capture <= (edge_capture & ~w1c) | edge_hit;
            read_q       <= read_word;
        end
    end

    assign bus.readdata = read_q;
    assign bus.irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_switches_irq.sv
// Randomised and directed checks of the switch PIO against a sample-window reference model.
module tb_soc_system_switches_irq;
    import soc_pio_pkg::*;

    localparam int W     = 4;
    localparam int S     = 2;
    localparam int DC    = 4;
    localparam int PRIME = S + DC + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [W-1:0]  in_port;
    logic [1:0]    addr;
    logic          write_n;
    logic [31:0]   wdata;
    int            n_checks = 0;
    int            n_fail   = 0;

    soc_system_switches_irq_if bus_r ();
    soc_system_switches_irq_if bus_a ();

    assign bus_r.address   = addr;
    assign bus_r.write_n   = write_n;
    assign bus_r.writedata = wdata;
    assign bus_a.address   = addr;
    assign bus_a.write_n   = write_n;
    assign bus_a.writedata = wdata;

    soc_system_switches_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(EDGE_RISING))
        dut_r (.clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus_r));
    soc_system_switches_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(EDGE_ANY))
        dut_a (.clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus_a));

    // Model index 0 = rising-edge instance, 1 = any-edge instance.
    logic [W-1:0] m_pipe   [2][S];
    logic [W-1:0] m_hist   [2][DC];
    logic [W-1:0] m_stable [2];
    logic [W-1:0] m_prev   [2];
    logic [W-1:0] m_mask   [2];
    logic [W-1:0] m_ec     [2];
    logic [31:0]  m_rd     [2];
    int           m_prime  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input logic rst_v, input logic [W-1:0] in_v,
                              input logic [1:0] a_v, input logic wn_v, input logic [31:0] wd_v);
        logic [W-1:0] sy, st, set, clr;
        logic [31:0]  rd;
        bit           all_diff;
        if (!rst_v) begin
            for (int s = 0; s < S; s++)  m_pipe[m][s] = '0;
            for (int d = 0; d < DC; d++) m_hist[m][d] = '0;
            m_stable[m] = '0; m_prev[m] = '0; m_mask[m] = '0; m_ec[m] = '0;
            m_rd[m] = '0; m_prime[m] = 0;
            return;
        end
        sy = m_pipe[m][S-1];
        st = m_stable[m];
        rd = '0;
        case (a_v)
            2'd0:    rd[W-1:0] = st;
            2'd1:    rd[W-1:0] = sy;
            2'd2:    rd[W-1:0] = m_mask[m];
            default: rd[W-1:0] = m_ec[m];
        endcase
        set = (m == 0) ? (st & ~m_prev[m]) : (st ^ m_prev[m]);
        if (m_prime[m] < PRIME) set = '0;
        clr = (!wn_v && a_v == 2'd3) ? wd_v[W-1:0] : '0;
        m_ec[m] = (m_ec[m] & ~clr) | set;
        if (!wn_v && a_v == 2'd2) m_mask[m] = wd_v[W-1:0];
        // A bit flips once its last DC synchronised samples all disagree with it.
        for (int d = DC-1; d > 0; d--) m_hist[m][d] = m_hist[m][d-1];
        m_hist[m][0] = sy;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int d = 0; d < DC; d++) if (m_hist[m][d][b] == st[b]) all_diff = 1'b0;
            if (all_diff) m_stable[m][b] = ~st[b];
        end
        m_prev[m] = st;
        for (int s = S-1; s > 0; s--) m_pipe[m][s] = m_pipe[m][s-1];
        m_pipe[m][0] = in_v;
        if (m_prime[m] < PRIME) m_prime[m]++;
        m_rd[m] = rd;
    endtask

    task automatic tick();
        logic r, wn;
        logic [W-1:0] iv;
        logic [1:0] av;
        logic [31:0] wd;
        r = reset_n; iv = in_port; av = addr; wn = write_n; wd = wdata;
        @(posedge clk);
        model_step(0, r, iv, av, wn, wd);
        model_step(1, r, iv, av, wn, wd);
        #1;
        check("rd_rise", bus_r.readdata, m_rd[0]);
        check("irq_rise", 32'(bus_r.irq), 32'(|(m_ec[0] & m_mask[0])));
        check("rd_any", bus_a.readdata, m_rd[1]);
        check("irq_any", 32'(bus_a.irq), 32'(|(m_ec[1] & m_mask[1])));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; write_n = 1'b0;
        tick();
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] vr, output logic [31:0] va);
        addr = a;
        tick();
        vr = bus_r.readdata;
        va = bus_a.readdata;
    endtask

    initial begin
        logic [31:0] vr, va;
        bit found;

        reset_n = 1'b0; in_port = 4'hF; addr = 2'd0; write_n = 1'b1; wdata = '0;
        ticks(3);
        reset_n = 1'b1;
        ticks(10);
        rd(2'd0, vr, va); check("t1_data", vr, 32'hF);
        rd(2'd3, vr, va); check("t1_edgecap", vr, 32'h0); check("t1_edgecap_any", va, 32'h0);
        check("t1_irq", 32'(bus_r.irq), 32'h0);

        in_port = 4'h0; ticks(10);
        wr(2'd3, 32'hF); wr(2'd2, 32'h1);
        addr = 2'd0; in_port = 4'h1;
        ticks(6);
        check("t2_irq_early", 32'(bus_r.irq), 32'h0);
        tick();
        check("t2_data", bus_r.readdata, 32'h1);
        check("t2_irq", 32'(bus_r.irq), 32'h1);
        rd(2'd3, vr, va); check("t2_edgecap", vr, 32'h1);
        wr(2'd3, 32'h1);
        check("t2_irq_clear", 32'(bus_r.irq), 32'h0);

        wr(2'd3, 32'hF);
        in_port = 4'h5; ticks(3); in_port = 4'h1; ticks(10);
        rd(2'd0, vr, va); check("t3_glitch_data", vr, 32'h1);
        rd(2'd3, vr, va); check("t3_glitch_edgecap", vr, 32'h0);
        in_port = 4'h5; ticks(4); in_port = 4'h1; ticks(12);
        rd(2'd3, vr, va); check("t3_pulse_edgecap", vr, 32'h4);
        rd(2'd0, vr, va); check("t3_pulse_data", vr, 32'h1);

        wr(2'd3, 32'hF);
        in_port = 4'h3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_stable[0][1] && !m_prev[0][1]) found = 1'b1;
            else tick();
        end
        check("t4_edge_seen", 32'(found), 32'h1);
        wr(2'd3, 32'h2);
        rd(2'd3, vr, va); check("t4_set_wins", vr & 32'h2, 32'h2);

        wr(2'd3, 32'hF); wr(2'd2, 32'h0);
        addr = 2'd0; in_port = 4'hB;
        ticks(6); check("t5_lat_old", bus_a.readdata, 32'h3);
        tick();   check("t5_lat_new", bus_a.readdata, 32'hB);
        ticks(4);
        rd(2'd3, vr, va); check("t5_rise", va & 32'h8, 32'h8);
        wr(2'd3, 32'h8);
        rd(2'd3, vr, va); check("t5_cleared", va & 32'h8, 32'h0);
        in_port = 4'h3; ticks(10);
        rd(2'd3, vr, va); check("t5_fall", va & 32'h8, 32'h8);
        check("t5_irq_masked", 32'(bus_a.irq), 32'h0);

        in_port = 4'h0; ticks(10);
        wr(2'd3, 32'hF);
        in_port = 4'h5; ticks(10);
        wr(2'd2, 32'hF);
        rd(2'd3, vr, va); check("t6_edgecap", vr, 32'h5);
        check("t6_irq_before", 32'(bus_r.irq), 32'h1);
        in_port = 4'hF; ticks(2);
        reset_n = 1'b0; tick();
        check("t6_rd_reset", bus_r.readdata, 32'h0);
        check("t6_irq_reset", 32'(bus_r.irq), 32'h0);
        check("t6_irq_any_reset", 32'(bus_a.irq), 32'h0);
        reset_n = 1'b1;
        rd(2'd2, vr, va); check("t6_mask", vr, 32'h0);
        rd(2'd3, vr, va); check("t6_edgecap_reset", vr, 32'h0);
        ticks(12);
        rd(2'd3, vr, va); check("t6_prime_edgecap", vr, 32'h0); check("t6_prime_any", va, 32'h0);
        rd(2'd0, vr, va); check("t6_data", vr, 32'hF);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) in_port = W'($urandom);
            addr    = 2'($urandom);
            write_n = ($urandom_range(0, 3) != 0);
            wdata   = $urandom;
            reset_n = ($urandom_range(0, 249) != 0);
            tick();
        end
        reset_n = 1'b1; write_n = 1'b1;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
